// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: ownership state encoding,
// default starvation limit and requester-select constants.
package dmem_arb_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_EXT  = 1'b1
  } arb_state_e;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int CNT_W_DEF        = 3;

  localparam logic SEL_CORE = 1'b0;
  localparam logic SEL_EXT  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating starvation counter. Clear has priority over increment; the count
// stops at the limit and at_limit flags that the waiting requester must win.
module arb_starve_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  assign at_limit = (cnt == limit);

  // Count denied cycles, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store path and an external port.
// The core has priority; a pending external request is forced through after
// STARVE_LIMIT denied cycles, and ext_lock hands the port to the external
// side until released. Optional statistics counters: DMEM_ARB_STATS_EN.
//
// Handshake: the external side holds ext_valid and its payload until it sees
// ext_valid && ext_ready in the same cycle; that edge commits a write or
// captures read data, which appears on ext_rdata with an ext_rvalid pulse
// one cycle later. ext_ready is combinational and may drop without an accept.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [31:0]      core_addr,
  input  logic [31:0]      core_wdata,
  output logic [31:0]      core_rdata,
  output logic             core_stall,
  input  logic             ext_valid,
  input  logic             ext_we,
  input  logic [31:0]      ext_addr,
  input  logic [31:0]      ext_wdata,
  input  logic             ext_lock,
  output logic             ext_ready,
  output logic             ext_rvalid,
  output logic [31:0]      ext_rdata,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  output logic [31:0]      stat_stalls,
  output logic [31:0]      stat_ext,
  output logic             dbg_state,
  output logic [CNT_W-1:0] dbg_starve_cnt
);

  arb_state_e       state_q, state_d;
  logic             grant_ext;
  logic             sel;
  logic             at_limit;
  logic [CNT_W-1:0] starve_cnt;
  logic             ext_accept;

  arb_starve_counter #(.CNT_W(CNT_W)) u_starve (
    .clk      (CLK),
    .rst_n    (RST),
    .inc      (ext_valid && !grant_ext),
    .clr      (!ext_valid || grant_ext),
    .limit    (CNT_W'(STARVE_LIMIT)),
    .cnt      (starve_cnt),
    .at_limit (at_limit)
  );

  // Ownership state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= OWN_CORE;
    else      state_q <= state_d;
  end

  // Lock entry needs the core idle or the starvation limit reached; release
  // takes effect from the next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OWN_CORE: if (ext_lock && (!core_req || at_limit)) state_d = OWN_EXT;
      OWN_EXT:  if (!ext_lock)                           state_d = OWN_CORE;
      default:  state_d = OWN_CORE;
    endcase
  end

  // Grant, stall and memory-port mux for the current owner.
  always_comb begin
    if (state_q == OWN_EXT) grant_ext = ext_valid;
    else                    grant_ext = ext_valid && (!core_req || at_limit);
    core_stall = core_req && (grant_ext || state_q == OWN_EXT);
    sel        = grant_ext ? SEL_EXT : SEL_CORE;
    if (sel == SEL_EXT) begin
      mem_we   = ext_we;
      mem_addr = ext_addr;
      mem_wd   = ext_wdata;
    end else begin
      mem_we   = core_we && core_req && !core_stall;
      mem_addr = core_addr;
      mem_wd   = core_wdata;
    end
  end

  assign ext_ready      = grant_ext;
  assign ext_accept     = ext_valid && grant_ext;
  assign core_rdata     = mem_rd;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_cnt;

  // Capture external read data one cycle after acceptance.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      ext_rvalid <= ext_accept && !ext_we;
      if (ext_accept && !ext_we) ext_rdata <= mem_rd;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stalls_q, ext_cnt_q;

  // Free-running statistics, wrapping at 2^32.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stalls_q  <= '0;
      ext_cnt_q <= '0;
    end else begin
      stalls_q  <= stalls_q  + {31'd0, core_stall};
      ext_cnt_q <= ext_cnt_q + {31'd0, ext_accept};
    end
  end

  assign stat_stalls = stalls_q;
  assign stat_ext    = ext_cnt_q;
`else
  assign stat_stalls = '0;
  assign stat_ext    = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic against a behavioural model of ownership, starvation and memory.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        CLK, RST;
  logic        core_req, core_we, ext_valid, ext_we, ext_lock;
  logic [31:0] core_addr, core_wdata, ext_addr, ext_wdata;
  logic [31:0] core_rdata, ext_rdata, mem_addr, mem_wd, mem_rd;
  logic [31:0] stat_stalls, stat_ext;
  logic        core_stall, ext_ready, ext_rvalid, mem_we, dbg_state;
  logic [2:0]  dbg_starve_cnt;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_lock(ext_lock), .ext_ready(ext_ready),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .stat_stalls(stat_stalls), .stat_ext(stat_ext),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- clock / environment memory ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] env_mem [16];
  assign mem_rd = env_mem[mem_addr[5:2]];
  always @(posedge CLK) if (mem_we) env_mem[mem_addr[5:2]] <= mem_wd;

  // ---------------- scoreboard / reference model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [16];
  logic [31:0] exp_q[$];
  bit          m_locked;
  int          m_starve;
  bit          m_rv;
  logic [31:0] m_rdata;
  int unsigned m_stalls, m_ext;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_starve = 0; m_rv = 0; m_rdata = '0;
    m_stalls = 0; m_ext = 0;
    exp_q.delete();
  endtask

  // One clock cycle: drive, check combinational + registered outputs against
  // the model, advance the model across the edge. Entered and left at negedge.
  task automatic step(input logic creq, input logic cwe, input logic [31:0] caddr,
                      input logic [31:0] cwd, input logic evalid, input logic ewe,
                      input logic [31:0] eaddr, input logic [31:0] ewd, input logic elock);
    bit g, s, w, nlock;
    logic [31:0] a, d;
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
    ext_valid = evalid; ext_we = ewe; ext_addr = eaddr; ext_wdata = ewd;
    ext_lock = elock;
    #1;
    chk("state", {31'd0, dbg_state}, {31'd0, m_locked});
    chk("starve", {29'd0, dbg_starve_cnt}, 32'(m_starve));
    chk("rvalid", {31'd0, ext_rvalid}, {31'd0, m_rv});
    if (m_rv) m_rdata = exp_q.pop_front();
    chk("rdata", ext_rdata, m_rdata);
    g = evalid && (m_locked || !creq || m_starve == LIMIT);
    s = creq && (g || m_locked);
    w = g ? ewe : (creq && cwe && !s);
    a = g ? eaddr : caddr;
    d = g ? ewd : cwd;
    chk("ready", {31'd0, ext_ready}, {31'd0, g});
    chk("stall", {31'd0, core_stall}, {31'd0, s});
    chk("mem_we", {31'd0, mem_we}, {31'd0, w});
    chk("mem_addr", mem_addr, a);
    chk("mem_wd", mem_wd, d);
    chk("core_rdata", core_rdata, ref_mem[a[5:2]]);
`ifdef DMEM_ARB_STATS_EN
    chk("stat_stalls", stat_stalls, m_stalls);
    chk("stat_ext", stat_ext, m_ext);
`else
    chk("stat_stalls", stat_stalls, 32'd0);
    chk("stat_ext", stat_ext, 32'd0);
`endif
    @(posedge CLK);
    m_rv = g && !ewe;
    if (m_rv) exp_q.push_back(ref_mem[eaddr[5:2]]);
    if (w) ref_mem[a[5:2]] = d;
    nlock = m_locked ? elock : (elock && (!creq || m_starve == LIMIT));
    m_starve = (!evalid || g) ? 0 : ((m_starve < LIMIT) ? m_starve + 1 : LIMIT);
    m_locked = nlock;
    m_stalls += s ? 1 : 0;
    m_ext += g ? 1 : 0;
    @(negedge CLK);
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #1;
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit lk;
    RST = 1'b0;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    ext_valid = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0; ext_lock = 0;
    for (int i = 0; i < 16; i++) begin env_mem[i] = '0; ref_mem[i] = '0; end
    model_reset();
    @(negedge CLK); @(negedge CLK);
    RST = 1'b1;
    chk("rst_rvalid", {31'd0, ext_rvalid}, 32'd0);
    chk("rst_state", {31'd0, dbg_state}, 32'd0);
    idle();

    // Core-only store then load.
    step(1, 1, 32'h20, 32'h1234_5678, 0, 0, 32'h0, 32'h0, 0);
    step(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    #0;
    core_req = 1; core_addr = 32'h20; #1;
    chk("core_readback", core_rdata, 32'h1234_5678);

    // External write then read of 0x10.
    step(0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0, 0);
    chk("ext_rd_pulse", {31'd0, ext_rvalid}, 32'd1);
    chk("ext_rd_data", ext_rdata, 32'hDEAD_BEEF);
    idle();

    // Starvation: core wins LIMIT cycles, then the external port is forced.
    for (int i = 0; i < LIMIT + 2; i++) begin
      step(1, 0, 32'h4, 32'h0, 1, 0, 32'h8, 32'h0, 0);
      if (i == LIMIT) chk("forced_starve", {29'd0, dbg_starve_cnt}, 32'd0);
    end
    idle();

    // Lock: enter with core idle, core stalls while locked, released next cycle.
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1);
    chk("locked", {31'd0, dbg_state}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 32'h24, 32'h55, 0, 0, 32'h0, 32'h0, 1);
    end
    step(1, 1, 32'h24, 32'h55, 0, 0, 32'h0, 32'h0, 0);
    core_req = 1; #1;
    chk("unlock_stall", {31'd0, core_stall}, 32'd0);
    step(1, 1, 32'h24, 32'h66, 0, 0, 32'h0, 32'h0, 0);
    idle();

    // Reset while an external read is being accepted.
    step(0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0, 0);
    idle();
    core_req = 0; ext_valid = 1; ext_we = 0; ext_addr = 32'h10; ext_lock = 1;
    #1;
    chk("rst_accept", {31'd0, ext_ready}, 32'd1);
    RST = 1'b0;
    #1;
    model_reset();
    @(posedge CLK); @(negedge CLK);
    RST = 1'b1;
    ext_valid = 0; ext_lock = 0;
    #1;
    chk("rst_no_pulse", {31'd0, ext_rvalid}, 32'd0);
    chk("rst_rdata", ext_rdata, 32'd0);
    chk("rst_state2", {31'd0, dbg_state}, 32'd0);
    chk("rst_starve", {29'd0, dbg_starve_cnt}, 32'd0);
    @(negedge CLK);
    idle();

    // Statistics: 3 forced stalls and 5 accepted external accesses.
    do_reset();
    step(0, 0, 32'h0, 32'h0, 1, 1, 32'h30, 32'h1, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 32'h4, 32'h0, 1, 1, 32'h34, 32'(i), 1);
    step(0, 0, 32'h0, 32'h0, 1, 0, 32'h30, 32'h0, 0);
    idle();
`ifdef DMEM_ARB_STATS_EN
    chk("stats_stalls", stat_stalls, 32'd3);
    chk("stats_ext", stat_ext, 32'd5);
`else
    chk("stats_stalls_off", stat_stalls, 32'd0);
    chk("stats_ext_off", stat_ext, 32'd0);
`endif

    // Randomized traffic.
    lk = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) lk = !lk;
      step($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
           {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, lk);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
